// File: rtl/stream_pkg.sv
// -----------------------------------------------------------------------------
// stream_pkg
//   Helpers shared by the valid/ready stream width converters.
//   - cnt_width(ratio)  : bits needed to hold a lane count 0..ratio
//   - lane_width(ratio) : bits needed to index ratio lanes (at least 1)
//   - lane_idx_t        : lane index wide enough for the largest legal ratio
// -----------------------------------------------------------------------------
package stream_pkg;

  localparam int MAX_RATIO = 64;

  typedef logic [$clog2(MAX_RATIO)-1:0] lane_idx_t;

  function automatic int cnt_width(input int ratio);
    return $clog2(ratio + 1);
  endfunction

  function automatic int lane_width(input int ratio);
    return (ratio > 1) ? $clog2(ratio) : 1;
  endfunction

endpackage

// File: rtl/stream_packer_if.sv
// -----------------------------------------------------------------------------
// stream_packer_if
//   Narrow input stream plus wide output stream of the stream_packer.
//   Parameters: BITS (input word width), RATIO (input words per output word).
//   Signals:
//     s_value/s_valid/s_ready   narrow input handshake
//     m_value/m_valid/m_ready   wide output handshake, m_count valid lanes
//     s_last/m_last             packet end flags, present only when
//                               STREAM_PACKER_LAST_EN is defined
//   Modports:
//     slave  : the packer's view (consumes s_*, produces m_*)
//     master : the environment's view (produces s_*, consumes m_*)
// -----------------------------------------------------------------------------
interface stream_packer_if
  import stream_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int RATIO = 4
) ();

  localparam int CNTW = cnt_width(RATIO);

  logic [BITS-1:0]       s_value;
  logic                  s_valid;
  logic                  s_ready;
  logic [BITS*RATIO-1:0] m_value;
  logic                  m_valid;
  logic                  m_ready;
  logic [CNTW-1:0]       m_count;
`ifdef STREAM_PACKER_LAST_EN
  logic                  s_last;
  logic                  m_last;
`endif

  modport slave (
    input  s_value, s_valid, m_ready,
`ifdef STREAM_PACKER_LAST_EN
    input  s_last,
    output m_last,
`endif
    output s_ready, m_value, m_valid, m_count
  );

  modport master (
    output s_value, s_valid, m_ready,
`ifdef STREAM_PACKER_LAST_EN
    output s_last,
    input  m_last,
`endif
    input  s_ready, m_value, m_valid, m_count
  );

endinterface

// File: rtl/stream_out_reg.sv
// -----------------------------------------------------------------------------
// stream_out_reg
//   Single-entry output holding register for valid/ready streams. A load
//   captures load_data and raises valid; the word is held stable until the
//   consumer takes it (valid & ready). A load in the same cycle as a take
//   replaces the word with valid staying high.
//   Ports:
//     clock, reset_n  rising-edge clock, asynchronous active-low reset
//     load            capture load_data this cycle (caller checks space)
//     load_data       payload to capture
//     ready           consumer accepts data this cycle
//     data, valid     held payload and its valid flag
//     space           a load this cycle will not overwrite an untaken word
// -----------------------------------------------------------------------------
module stream_out_reg #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             space
);

  assign space = !valid || ready;

  // NOTE: flops use non-blocking assignments so every register samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data  <= '0;
      valid <= 1'b0;
    end else if (load) begin
      data  <= load_data;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/stream_packer.sv
// -----------------------------------------------------------------------------
// stream_packer
//   Width-up converter: packs RATIO consecutive BITS-wide input words into one
//   BITS*RATIO-wide output word, first accepted word in lane 0.
//   Ports:
//     clock, reset_n  rising-edge clock, asynchronous active-low reset
//     bus             stream_packer_if.slave (s_* input, m_* output)
//   Optional feature: STREAM_PACKER_LAST_EN adds s_last/m_last; s_last ends
//   the current word early, emitting a partial word with zeroed upper lanes.
//   Filling lanes never stalls; only the word-completing input waits for the
//   output register to have space.
// -----------------------------------------------------------------------------
module stream_packer
  import stream_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int RATIO = 4
) (
  input  logic           clock,
  input  logic           reset_n,
  stream_packer_if.slave bus
);

  localparam int CNTW = cnt_width(RATIO);
  localparam int LW   = lane_width(RATIO);
  localparam int DW   = BITS * RATIO;
`ifdef STREAM_PACKER_LAST_EN
  localparam int PW   = DW + CNTW + 1;
`else
  localparam int PW   = DW + CNTW;
`endif

  logic [LW-1:0]                cnt;
  lane_idx_t                    cnt_idx;
  logic [RATIO-1:0][BITS-1:0]   acc;
  logic [RATIO-1:0][BITS-1:0]   packed_word;
  logic [RATIO-1:0]             lane_we;
  logic [CNTW-1:0]              load_count;
  logic [PW-1:0]                load_data;
  logic [PW-1:0]                out_data;
  logic                         last_in;
  logic                         candidate;
  logic                         space;
  logic                         accept;
  logic                         complete;
  logic                         fill;

`ifdef STREAM_PACKER_LAST_EN
  assign last_in = bus.s_last;
`else
  assign last_in = 1'b0;
`endif

  assign cnt_idx   = lane_idx_t'(cnt);
  // The word currently presented would complete the output word if accepted.
  assign candidate = (cnt_idx == lane_idx_t'(RATIO - 1)) || last_in;
  // Independent of s_valid so upstream may wait on ready before asserting valid.
  assign bus.s_ready = !candidate || space;
  assign accept      = bus.s_valid && bus.s_ready;
  assign complete    = accept && candidate;
  assign fill        = accept && !candidate;

  // Lane write-enable decode for non-completing accepts.
  always_comb begin
    lane_we = '0;
    for (int k = 0; k < RATIO; k++) begin
      lane_we[k] = fill && (cnt_idx == lane_idx_t'(k));
    end
  end

  // Outgoing word: accumulated lanes with the current input in lane cnt.
  // Lanes above cnt are already zero because acc clears on every completion.
  // NOTE: every always_comb output gets a full default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    packed_word = acc;
    for (int k = 0; k < RATIO; k++) begin
      if (cnt_idx == lane_idx_t'(k)) begin
        packed_word[k] = bus.s_value;
      end
    end
  end

  // NOTE: acc is reset rather than left undefined: its zero upper lanes are
  // emitted as-is on a short word, so stale data must never survive.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      acc <= '0;
      cnt <= '0;
    end else if (complete) begin
      acc <= '0;
      cnt <= '0;
    end else begin
      for (int k = 0; k < RATIO; k++) begin
        if (lane_we[k]) begin
          acc[k] <= bus.s_value;
        end
      end
      if (fill) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign load_count = CNTW'(cnt) + CNTW'(1);

`ifdef STREAM_PACKER_LAST_EN
  assign load_data  = {last_in, load_count, packed_word};
  assign bus.m_last = out_data[PW-1];
`else
  assign load_data  = {load_count, packed_word};
`endif

  stream_out_reg #(
    .WIDTH(PW)
  ) u_out_reg (
    .clock    (clock),
    .reset_n  (reset_n),
    .load     (complete),
    .load_data(load_data),
    .ready    (bus.m_ready),
    .data     (out_data),
    .valid    (bus.m_valid),
    .space    (space)
  );

  assign bus.m_value = out_data[DW-1:0];
  assign bus.m_count = out_data[DW +: CNTW];

endmodule

// File: tb/tb_stream_packer.sv
// -----------------------------------------------------------------------------
// tb_stream_packer
//   Self-checking bench for stream_packer (BITS=8, RATIO=4). Accepted input
//   words feed a queue-based packing model; a monitor pops the expected word
//   on every output handshake and also checks that a stalled word is held.
//   Covers STREAM_PACKER_LAST_EN when the macro is defined.
// -----------------------------------------------------------------------------
module tb_stream_packer;

  localparam int BITS  = 8;
  localparam int RATIO = 4;
  localparam int W     = BITS * RATIO;

  typedef struct {
    logic [W-1:0] value;
    int           count;
    bit           lst;
  } exp_t;

  logic clock;
  logic reset_n;

  stream_packer_if #(.BITS(BITS), .RATIO(RATIO)) bus ();

  stream_packer #(.BITS(BITS), .RATIO(RATIO)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  int           n_compared   = 0;
  int           n_mismatched = 0;
  exp_t         exp_q[$];
  logic [7:0]   cur_q[$];
  bit           rand_ready   = 1'b0;
  bit           hold_prev    = 1'b0;
  logic [W-1:0] prev_value;
  logic [2:0]   prev_count;
  int           gap;
  bit           lst;
  logic [7:0]   seq8 [8];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference packing: collect accepted words, emit on RATIO words or last.
  task automatic model_accept(input logic [7:0] w, input bit l);
    exp_t e;
    cur_q.push_back(w);
    if (cur_q.size() == RATIO || l) begin
      e.value = '0;
      foreach (cur_q[i]) e.value |= W'(cur_q[i]) << (i * BITS);
      e.count = cur_q.size();
      e.lst   = l;
      exp_q.push_back(e);
      cur_q.delete();
    end
  endtask

  // Present one word from posedge+1, wait (bounded) for acceptance.
  task automatic send(input logic [7:0] w, input bit l);
    bit done;
    done        = 1'b0;
    bus.s_value = w;
    bus.s_valid = 1'b1;
`ifdef STREAM_PACKER_LAST_EN
    bus.s_last  = l;
`endif
    for (int t = 0; t < 200 && !done; t++) begin
      @(negedge clock);
      if (bus.s_ready) begin
        model_accept(w, l);
        done = 1'b1;
      end
    end
    if (!done) begin
      n_compared++;
      n_mismatched++;
      $display("FAIL send_timeout: word 0x%0h not accepted within 200 cycles", w);
    end
    @(posedge clock);
    #1;
    bus.s_valid = 1'b0;
`ifdef STREAM_PACKER_LAST_EN
    bus.s_last  = 1'b0;
`endif
  endtask

  // Monitor: compares every output handshake against the scoreboard and
  // checks that a stalled output word stays put.
  initial begin
    forever begin
      @(negedge clock);
      if (!reset_n) begin
        hold_prev = 1'b0;
      end else begin
        if (hold_prev) begin
          check("hold_valid", 64'(bus.m_valid), 64'h1);
          check("hold_value", 64'(bus.m_value), 64'(prev_value));
          check("hold_count", 64'(bus.m_count), 64'(prev_count));
        end
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL unexpected_output: got 0x%0h with none expected", bus.m_value);
          end else begin
            exp_t e;
            e = exp_q.pop_front();
            check("out_value", 64'(bus.m_value), 64'(e.value));
            check("out_count", 64'(bus.m_count), 64'(e.count));
`ifdef STREAM_PACKER_LAST_EN
            check("out_last", 64'(bus.m_last), 64'(e.lst));
`endif
          end
        end
        hold_prev  = bus.m_valid && !bus.m_ready;
        prev_value = bus.m_value;
        prev_count = bus.m_count;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.s_value = '0;
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b0;
`ifdef STREAM_PACKER_LAST_EN
    bus.s_last  = 1'b0;
`endif
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("rst_s_ready", 64'(bus.s_ready), 64'h1);
    check("rst_m_valid", 64'(bus.m_valid), 64'h0);
    check("rst_m_value", 64'(bus.m_value), 64'h0);
    check("rst_m_count", 64'(bus.m_count), 64'h0);
`ifdef STREAM_PACKER_LAST_EN
    check("rst_m_last", 64'(bus.m_last), 64'h0);
`endif
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Back-to-back fill with m_ready high: one-cycle m_valid pulse.
    bus.m_ready = 1'b1;
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    send(8'h44, 1'b0);
    check("t1_valid_rise", 64'(bus.m_valid), 64'h1);
    check("t1_value", 64'(bus.m_value), 64'h44332211);
    check("t1_count", 64'(bus.m_count), 64'h4);
    @(posedge clock);
    #1;
    check("t1_valid_fall", 64'(bus.m_valid), 64'h0);

    // Output blocked: lanes keep filling, completing word stalls.
    bus.m_ready = 1'b0;
    seq8 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    for (int i = 0; i < 7; i++) send(seq8[i], 1'b0);
    check("t2_held_value", 64'(bus.m_value), 64'h44332211);
    bus.s_value = seq8[7];
    bus.s_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      check("t2_stall_ready", 64'(bus.s_ready), 64'h0);
    end
    @(posedge clock);
    #1 bus.m_ready = 1'b1;
    #1;
    check("t2_unstall_ready", 64'(bus.s_ready), 64'h1);
    model_accept(seq8[7], 1'b0);
    @(posedge clock);
    #1;
    bus.s_valid = 1'b0;
    check("t3_valid_cont", 64'(bus.m_valid), 64'h1);
    check("t3_value", 64'(bus.m_value), 64'h88776655);
    @(posedge clock);
    #1;
    check("t3_valid_fall", 64'(bus.m_valid), 64'h0);

`ifdef STREAM_PACKER_LAST_EN
    // Early completion by s_last.
    send(8'hAA, 1'b0);
    send(8'hBB, 1'b1);
    check("last_value", 64'(bus.m_value), 64'h0000BBAA);
    check("last_count", 64'(bus.m_count), 64'h2);
    check("last_flag", 64'(bus.m_last), 64'h1);
    for (int i = 0; i < 4; i++) send(8'(i + 1), 1'b0);
    check("after_last_value", 64'(bus.m_value), 64'h04030201);
    check("after_last_flag", 64'(bus.m_last), 64'h0);
`endif

    // Reset mid-packet with a word held at the output.
    bus.m_ready = 1'b0;
    for (int i = 0; i < 4; i++) send(8'(8'h0A + i), 1'b0);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    check("pre_rst_valid", 64'(bus.m_valid), 64'h1);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", 64'(bus.m_valid), 64'h0);
    check("mid_rst_value", 64'(bus.m_value), 64'h0);
    check("mid_rst_count", 64'(bus.m_count), 64'h0);
    check("mid_rst_ready", 64'(bus.s_ready), 64'h1);
    exp_q.delete();
    cur_q.delete();
    repeat (2) @(posedge clock);
    #1;
    reset_n     = 1'b1;
    bus.m_ready = 1'b1;
    for (int i = 0; i < 4; i++) send(8'(8'h05 + i), 1'b0);
    check("post_rst_value", 64'(bus.m_value), 64'h08070605);

    // Randomized gaps and backpressure.
    rand_ready = 1'b1;
    fork
      begin
        while (rand_ready) begin
          @(posedge clock);
          #1;
          if (rand_ready) bus.m_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int n = 0; n < 1000; n++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      repeat (gap) begin
        @(posedge clock);
        #1;
      end
`ifdef STREAM_PACKER_LAST_EN
      lst = ($urandom_range(0, 5) == 0);
`else
      lst = 1'b0;
`endif
      send(8'($urandom), lst);
    end
`ifdef STREAM_PACKER_LAST_EN
    send(8'h5A, 1'b1);
`endif
    rand_ready = 1'b0;
    @(posedge clock);
    #1 bus.m_ready = 1'b1;
    for (int t = 0; t < 200 && exp_q.size() != 0; t++) @(posedge clock);
    #1;
    check("drain_left", 64'(exp_q.size()), 64'h0);
    check("drain_valid", 64'(bus.m_valid), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
